// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin arbiter feeding the crossbar routing matrix.
// Each slave port owns a two-state FSM (IDLE/BUSY) and a round-robin pointer.
// A grant is held from the arbitration edge until the slave strobes s_ack.
// A master already holding a grant is excluded from arbitration on every slave.

package cross_bar_pkg;
  localparam int MASTER_N = 4;
  typedef logic [$clog2(MASTER_N)-1:0] master_num_t;
endpackage

// Invariant checker: grant bookkeeping must stay consistent between the
// master-side and slave-side views.
module cross_bar_arbiter_chk #(
  parameter  int MASTER_N = cross_bar_pkg::MASTER_N,
  localparam int W        = $clog2(MASTER_N)
) (
  input logic                         clk,
  input logic                         rst,
  input logic [MASTER_N-1:0][W-1:0]   s_sel,
  input logic [MASTER_N-1:0]          s_sel_vld,
  input logic [MASTER_N-1:0]          m_gnt
);

  // Check both invariants on every edge outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert ($countones(m_gnt) == $countones(s_sel_vld))
        else $error("cross_bar_arbiter: m_gnt count %0d differs from s_sel_vld count %0d",
                    $countones(m_gnt), $countones(s_sel_vld));
      for (int s = 0; s < MASTER_N; s++) begin
        if (s_sel_vld[s]) begin
          assert (m_gnt[s_sel[s]])
            else $error("cross_bar_arbiter: slave %0d selects master %0d without its m_gnt",
                        s, s_sel[s]);
        end
      end
    end
  end

endmodule

module cross_bar_arbiter #(
  parameter  int MASTER_N = cross_bar_pkg::MASTER_N,
  localparam int W        = $clog2(MASTER_N)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MASTER_N-1:0]         m_req,
  input  logic [MASTER_N-1:0][W-1:0]  m_target,
  input  logic [MASTER_N-1:0]         s_ack,
  output logic [MASTER_N-1:0][W-1:0]  s_sel,
  output logic [MASTER_N-1:0]         s_sel_vld,
  output logic [MASTER_N-1:0]         m_gnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                       state_q [MASTER_N];
  logic [MASTER_N-1:0][W-1:0]   s_sel_q;
  logic [MASTER_N-1:0][W-1:0]   rr_ptr_q;
  logic [MASTER_N-1:0]          s_sel_vld_q;
  logic [MASTER_N-1:0]          m_gnt_q;

  // Per-slave arbitration result, valid only when that slave is IDLE.
  logic [MASTER_N-1:0]          win_vld_d;
  logic [MASTER_N-1:0][W-1:0]   win_idx_d;

  // Round-robin successor of a winning master index, wrapping at MASTER_N-1.
  function automatic logic [W-1:0] next_ptr(input logic [W-1:0] idx);
    logic [W-1:0] res;
    if (idx == W'(MASTER_N - 1)) begin
      res = '0;
    end else begin
      res = idx + 1'b1;
    end
    return res;
  endfunction

  // Scan masters from each slave's pointer and pick the first eligible one;
  // exclusion uses the registered grant flags, so parallel slaves cannot
  // both pick a master that already holds a grant.
  always_comb begin
    int          cand;
    logic [W-1:0] cand_idx;
    win_vld_d = '0;
    win_idx_d = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int s = 0; s < MASTER_N; s++) begin
      for (int k = 0; k < MASTER_N; k++) begin
        cand     = (int'(rr_ptr_q[s]) + k) % MASTER_N;
        cand_idx = W'(cand);
        if (!win_vld_d[s] && m_req[cand_idx] &&
            (m_target[cand_idx] == W'(s)) && !m_gnt_q[cand_idx]) begin
          win_vld_d[s] = 1'b1;
          win_idx_d[s] = cand_idx;
        end else begin
          win_vld_d[s] = win_vld_d[s];
        end
      end
    end
  end

  // Per-slave FSMs with registered select/valid/grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MASTER_N; s++) begin
        state_q[s] <= IDLE;
      end
      s_sel_q     <= '0;
      rr_ptr_q    <= '0;
      s_sel_vld_q <= '0;
      m_gnt_q     <= '0;
    end else begin
      for (int s = 0; s < MASTER_N; s++) begin
        case (state_q[s])
          IDLE: begin
            if (win_vld_d[s]) begin
              s_sel_q[s]              <= win_idx_d[s];
              s_sel_vld_q[s]          <= 1'b1;
              m_gnt_q[win_idx_d[s]]   <= 1'b1;
              rr_ptr_q[s]             <= next_ptr(win_idx_d[s]);
              state_q[s]              <= BUSY;
            end else begin
              state_q[s] <= IDLE;
            end
          end
          BUSY: begin
            // Release keeps s_sel so the matrix select does not glitch.
            if (s_ack[s]) begin
              s_sel_vld_q[s]       <= 1'b0;
              m_gnt_q[s_sel_q[s]]  <= 1'b0;
              state_q[s]           <= IDLE;
            end else begin
              state_q[s] <= BUSY;
            end
          end
          default: begin
            s_sel_vld_q[s] <= 1'b0;
            state_q[s]     <= IDLE;
          end
        endcase
      end
    end
  end

  assign s_sel     = s_sel_q;
  assign s_sel_vld = s_sel_vld_q;
  assign m_gnt     = m_gnt_q;

  cross_bar_arbiter_chk #(.MASTER_N(MASTER_N)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .s_sel     (s_sel_q),
    .s_sel_vld (s_sel_vld_q),
    .m_gnt     (m_gnt_q)
  );

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Self-checking bench for cross_bar_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction-level
// ownership model every cycle.
module tb_cross_bar_arbiter;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        m_req = '0;
  logic [N-1:0][1:0]   m_target = '0;
  logic [N-1:0]        s_ack = '0;
  logic [N-1:0][1:0]   s_sel;
  logic [N-1:0]        s_sel_vld;
  logic [N-1:0]        m_gnt;

  int checks   = 0;
  int failures = 0;

  // Model: which master owns each slave (-1 = none), last select, rr pointer.
  int own  [N];
  int msel [N];
  int rr   [N];

  cross_bar_arbiter #(.MASTER_N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_target  (m_target),
    .s_ack     (s_ack),
    .s_sel     (s_sel),
    .s_sel_vld (s_sel_vld),
    .m_gnt     (m_gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the ownership model by one clock edge using the current inputs.
  task automatic model_update();
    int  nown [N];
    bit  held [N];
    bit  found;
    int  c;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        own[i] = -1; msel[i] = 0; rr[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) held[i] = 1'b0;
      for (int s = 0; s < N; s++) if (own[s] >= 0) held[own[s]] = 1'b1;
      for (int s = 0; s < N; s++) begin
        nown[s] = own[s];
        if (own[s] >= 0) begin
          if (s_ack[s]) nown[s] = -1;
        end else begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            c = (rr[s] + k) % N;
            if (!found && m_req[c] && int'(m_target[c]) == s && !held[c]) begin
              found   = 1'b1;
              nown[s] = c;
              msel[s] = c;
              rr[s]   = (c + 1) % N;
            end
          end
        end
      end
      for (int s = 0; s < N; s++) own[s] = nown[s];
    end
  endtask

  task automatic compare_all();
    logic [N-1:0][1:0] es;
    logic [N-1:0]      ev;
    logic [N-1:0]      eg;
    es = '0; ev = '0; eg = '0;
    for (int s = 0; s < N; s++) begin
      es[s] = 2'(msel[s]);
      if (own[s] >= 0) begin
        ev[s]      = 1'b1;
        eg[own[s]] = 1'b1;
      end
    end
    chk("model_s_sel",     32'(s_sel),     32'(es));
    chk("model_s_sel_vld", 32'(s_sel_vld), 32'(ev));
    chk("model_m_gnt",     32'(m_gnt),     32'(eg));
  endtask

  // One clock edge: update model at the edge, compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    logic [1:0] rr_exp [6];
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd3;
    rr_exp[3] = 2'd0; rr_exp[4] = 2'd1; rr_exp[5] = 2'd3;

    // Reset held 2 cycles with random requests.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_req = 4'($urandom);
      for (int m = 0; m < N; m++) m_target[m] = 2'($urandom);
      tick();
      chk("rst_vld", 32'(s_sel_vld), 32'd0);
      chk("rst_gnt", 32'(m_gnt),     32'd0);
      chk("rst_sel", 32'(s_sel),     32'd0);
    end
    rst = 1'b0; m_req = '0; m_target = '0;
    tick();
    chk("post_rst_vld", 32'(s_sel_vld), 32'd0);
    chk("post_rst_gnt", 32'(m_gnt),     32'd0);

    // Single transaction m2 -> s1.
    m_req = 4'b0100; m_target[2] = 2'd1;
    tick();
    chk("single_sel1", 32'(s_sel[1]),  32'd2);
    chk("single_vld",  32'(s_sel_vld), 32'b0010);
    chk("single_gnt",  32'(m_gnt),     32'b0100);
    tick(); tick();
    chk("single_hold_vld", 32'(s_sel_vld), 32'b0010);
    s_ack[1] = 1'b1;
    tick();
    s_ack = '0; m_req = '0;
    chk("single_rel_vld", 32'(s_sel_vld), 32'd0);
    chk("single_rel_gnt", 32'(m_gnt),     32'd0);
    chk("single_rel_sel", 32'(s_sel[1]),  32'd2);
    tick();
    s_ack[1] = 1'b1;
    tick();
    s_ack = '0;
    chk("idle_ack_vld", 32'(s_sel_vld), 32'd0);
    chk("idle_ack_gnt", 32'(m_gnt),     32'd0);

    // Round robin on s0 with wrap: m0, m1, m3.
    m_target = '0; m_req = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_vld",   32'(s_sel_vld[0]), 32'd1);
      chk("rr_order", 32'(s_sel[0]),     32'(rr_exp[i]));
      s_ack[0] = 1'b1;
      tick();
      s_ack[0] = 1'b0;
      chk("rr_gap", 32'(s_sel_vld[0]), 32'd0);
    end
    m_req = '0;

    // Parallel slaves: m0 -> s2, m1 -> s3.
    m_target[0] = 2'd2; m_target[1] = 2'd3; m_req = 4'b0011;
    tick();
    chk("par_sel2", 32'(s_sel[2]),  32'd0);
    chk("par_sel3", 32'(s_sel[3]),  32'd1);
    chk("par_vld",  32'(s_sel_vld), 32'b1100);
    chk("par_gnt",  32'(m_gnt),     32'b0011);
    m_req = '0; s_ack = 4'b1100;
    tick();
    s_ack = '0;

    // Exclusion: m1 granted on s0, then retargets s2 while holding.
    m_target = '0; m_req = 4'b0010;
    tick();
    chk("excl_sel0", 32'(s_sel[0]), 32'd1);
    m_target[1] = 2'd2;
    tick(); tick();
    chk("excl_vld", 32'(s_sel_vld), 32'b0001);
    chk("excl_gnt", 32'(m_gnt),     32'b0010);
    s_ack[0] = 1'b1;
    tick();
    s_ack = '0;
    chk("excl_rel_vld", 32'(s_sel_vld), 32'd0);
    tick();
    chk("excl_s2_vld", 32'(s_sel_vld), 32'b0100);
    chk("excl_s2_sel", 32'(s_sel[2]),  32'd1);
    chk("excl_s2_gnt", 32'(m_gnt),     32'b0010);
    m_req = '0; s_ack[2] = 1'b1;
    tick();
    s_ack = '0;

    // Reset mid-BUSY: m0,m2 contend for s0 (rr[0]=2 now), m3 -> s3.
    m_target = '0; m_target[3] = 2'd3; m_req = 4'b1101;
    tick();
    chk("mid_pre_sel0", 32'(s_sel[0]),  32'd2);
    chk("mid_pre_vld",  32'(s_sel_vld), 32'b1001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", 32'(s_sel_vld), 32'd0);
    chk("mid_rst_gnt", 32'(m_gnt),     32'd0);
    tick();
    chk("mid_post_sel0", 32'(s_sel[0]),  32'd0);
    chk("mid_post_sel3", 32'(s_sel[3]),  32'd3);
    chk("mid_post_vld",  32'(s_sel_vld), 32'b1001);
    chk("mid_post_gnt",  32'(m_gnt),     32'b1001);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      m_req = 4'($urandom);
      for (int m = 0; m < N; m++) m_target[m] = 2'($urandom);
      s_ack = 4'($urandom & $urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cross_bar_arbiter.md
Name: cross_bar_arbiter

Overview:
- Per-slave round-robin arbiter that sits directly upstream of the crossbar routing matrix.
- Each master presents a request and a target slave index.
- For every slave port, the block produces the registered index of the master granted to it. This is the `master_num_t` select vector the matrix consumes.
- A grant is held for a whole transaction until the slave acknowledges completion.

Parameters:
- MASTER_N, `cross_bar_pkg::MASTER_N` (default 4): number of masters, which equals the number of slaves (square matrix). Must be ≥2.
- `master_num_t`, `cross_bar_pkg::master_num_t`: master/slave index type, width `$clog2(MASTER_N)`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req  in  MASTER_N  per-master request; held high for the whole transaction.
- m_target  in  MASTER_N x `master_num_t`  per-master target slave index; valid while m_req is high.
- s_ack  in  MASTER_N  per-slave transaction-complete strobe, 1 cycle.
- s_sel  out  MASTER_N x `master_num_t`  per-slave granted master index; drives the matrix select input.
- s_sel_vld  out  MASTER_N  per-slave grant-active flag.
- m_gnt  out  MASTER_N  per-master granted flag.

Behaviour:
- Reset (rst=1 at an edge):
  - s_sel = 0, s_sel_vld = 0, m_gnt = 0 at the next edge.
  - All slave FSMs go to IDLE.
  - All round-robin pointers rr_ptr[s] = 0.
  - Reset applied mid-transaction drops every grant; no ack is required.
- Per-slave FSM, states IDLE and BUSY.
- IDLE:
  - Eligible master m for slave s: `m_req[m] && m_target[m]==s && !m_gnt[m]`.
  - If any master is eligible, pick the first one scanning m = rr_ptr[s], rr_ptr[s]+1, … modulo MASTER_N.
  - At the next edge: s_sel[s]=m, s_sel_vld[s]=1, m_gnt[m]=1, state→BUSY, rr_ptr[s]=(m+1) mod MASTER_N (wraps MASTER_N-1→0).
  - Request-to-grant latency is 1 cycle.
- BUSY:
  - s_sel[s] and the grant are frozen.
  - m_req and m_target changes of the granted master are ignored.
  - s_ack[s]=1 → at the next edge: s_sel_vld[s]=0, m_gnt[that master]=0, state→IDLE. s_sel[s] keeps its last value.
  - Re-arbitration happens in the IDLE cycle after release, so back-to-back transactions on one slave have a 1-cycle bubble.
- s_ack[s] while slave s is IDLE: ignored.
- Granted-master exclusion: a master with m_gnt=1 is not eligible on any slave. A master therefore never holds two grants.
- Same-cycle arbitration: when several slaves arbitrate in the same cycle, exclusion uses the registered m_gnt. Targets are single-valued, so one master cannot win two slaves in the same cycle.
- Independent slaves arbitrate in parallel, with no ordering between them.
- Invariants checked by assertions:
  - popcount(m_gnt) == popcount(s_sel_vld).
  - For every s with s_sel_vld[s]=1: m_gnt[s_sel[s]]=1.

Test Plan:
- Reset: hold rst 2 cycles with random m_req → s_sel_vld=0, m_gnt=0, s_sel=0 throughout and at the first cycle after reset.
- Single transaction: m_req[2]=1, m_target[2]=1 at cycle 1 → cycle 2: s_sel[1]=2, s_sel_vld[1]=1, m_gnt[2]=1. s_ack[1] at cycle 5 → cycle 6: s_sel_vld[1]=0, m_gnt[2]=0. s_ack[1] at cycle 7 (IDLE) has no effect.
- Round robin with wrap:
  - Stimulus: m0, m1, m3 request slave 0 continuously; each grant acked 1 cycle after it appears.
  - Expected: grant order 0, 1, 3, 0, 1, 3 with a 1-cycle idle gap between grants.
  - rr_ptr after m3 wraps to 0.
- Parallel slaves: m0→s2 and m1→s3 in the same cycle → next cycle s_sel[2]=0 and s_sel[3]=1, both vld; m_gnt=4'b0011.
- Exclusion:
  - m1 is granted on s0, then retargets to s2 with m_req held high. s2 stays IDLE with no grant to m1.
  - After s_ack[0], m1 is granted on s2 two cycles later: the cycle after ack releases s0, and the following cycle registers the s2 grant.
- Reset mid-BUSY: slaves 0 and 3 are BUSY when rst is pulsed for 1 cycle → all vld/gnt are 0 the next cycle. With the same requests still held, the first post-reset grants follow rr_ptr=0 priority.
